// File: rtl/mux_2_arbiter.sv
// rtl/mux_2_arbiter.sv - round-robin arbiter driving a shared 2:1 mux output stream
module mux_2_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_A    = 2'd1;
  localparam logic [1:0] ST_B    = 2'd2;

  // last_q: 0 = A held the previous tenure, 1 = B did
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     hold_q, hold_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              xfer;

  assign gnt_a     = (state_q == ST_A);
  assign gnt_b     = (state_q == ST_B);
  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

  // A word moves only when the owner is still requesting
  assign xfer = (gnt_a && req_a) || (gnt_b && req_b);

  // Grant sequencing: round-robin on contention, tenure capped at MAX_HOLD cycles
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (req_a && req_b) state_d = last_q ? ST_A : ST_B;
        else if (req_a)     state_d = ST_A;
        else if (req_b)     state_d = ST_B;
      end
      ST_A: begin
        if (!req_a) begin
          state_d = req_b ? ST_B : ST_IDLE;
          last_d  = 1'b0;
          hold_d  = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CW'(1);
        end else if (req_b) begin
          state_d = ST_B;
          last_d  = 1'b0;
          hold_d  = '0;
        end else begin
          // Nobody else waiting: renew the tenure without a bubble
          hold_d = '0;
        end
      end
      ST_B: begin
        if (!req_b) begin
          state_d = req_a ? ST_A : ST_IDLE;
          last_d  = 1'b1;
          hold_d  = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CW'(1);
        end else if (req_a) begin
          state_d = ST_A;
          last_d  = 1'b1;
          hold_d  = '0;
        end else begin
          hold_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Select follows the next owner and keeps its value while idle
  always_comb begin
    sel_d = sel_q;
    if (state_d == ST_B)      sel_d = 1'b1;
    else if (state_d == ST_A) sel_d = 1'b0;
  end

  // Output stream: capture the owner's word only on a real transfer
  always_comb begin
    out_valid_d = xfer;
    out_d       = out_q;
    if (xfer) out_d = gnt_b ? data_b : data_a;
  end

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mux_2_arbiter.sv
// tb/tb_mux_2_arbiter.sv - randomized and directed checks of mux_2_arbiter against a tenure model
module tb_mux_2_arbiter;

  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          gnt_a, gnt_b, sel, out_valid;
  logic [DW-1:0] out;

  int total = 0;
  int bad   = 0;

  // model: owner 0=none 1=A 2=B; ten = grant cycles so far in this tenure
  int            m_own;
  int            m_ten;
  int            m_last;
  logic          m_sel;
  logic [DW-1:0] m_out;
  logic          m_ov;

  always #5 clk = ~clk;

  mux_2_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out(out), .out_valid(out_valid)
  );

  task automatic model_edge(input logic r, input logic a, input logic b,
                            input logic [DW-1:0] da, input logic [DW-1:0] db);
    int  x, y;
    logic rx, ry;
    if (r) begin
      m_own = 0; m_ten = 0; m_last = 2; m_sel = 1'b0; m_out = '0; m_ov = 1'b0;
      return;
    end
    m_ov = (m_own == 1 && a) || (m_own == 2 && b);
    if (m_ov) m_out = (m_own == 2) ? db : da;
    if (m_own == 0) begin
      if (a && b)  m_own = (m_last == 2) ? 1 : 2;
      else if (a)  m_own = 1;
      else if (b)  m_own = 2;
      m_ten = (m_own != 0) ? 1 : 0;
    end else begin
      x  = m_own;
      y  = 3 - m_own;
      rx = (x == 1) ? a : b;
      ry = (y == 1) ? a : b;
      if (!rx) begin
        m_last = x; m_own = ry ? y : 0; m_ten = ry ? 1 : 0;
      end else if (m_ten >= MH && ry) begin
        m_last = x; m_own = y; m_ten = 1;
      end else if (m_ten >= MH) begin
        m_ten = 1;
      end else begin
        m_ten = m_ten + 1;
      end
    end
    if (m_own == 2)      m_sel = 1'b1;
    else if (m_own == 1) m_sel = 1'b0;
  endtask

  task automatic check_all(input string tag);
    total++;
    assert (gnt_a === (m_own == 1)) else begin
      bad++; $error("FAIL %s gnt_a got=%0b exp=%0b", tag, gnt_a, (m_own == 1));
    end
    total++;
    assert (gnt_b === (m_own == 2)) else begin
      bad++; $error("FAIL %s gnt_b got=%0b exp=%0b", tag, gnt_b, (m_own == 2));
    end
    total++;
    assert (sel === m_sel) else begin
      bad++; $error("FAIL %s sel got=%0b exp=%0b", tag, sel, m_sel);
    end
    total++;
    assert (out_valid === m_ov) else begin
      bad++; $error("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, m_ov);
    end
    total++;
    assert (out === m_out) else begin
      bad++; $error("FAIL %s out got=%h exp=%h", tag, out, m_out);
    end
    total++;
    assert ((gnt_a & gnt_b) === 1'b0) else begin
      bad++; $error("FAIL %s both_gnt got=%0b exp=0", tag, gnt_a & gnt_b);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, compare at negedge
  task automatic step(input string tag, input logic r, input logic a, input logic b,
                      input logic [DW-1:0] da, input logic [DW-1:0] db);
    rst = r; req_a = a; req_b = b; data_a = da; data_b = db;
    model_edge(r, a, b, da, db);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  initial begin
    logic a, b;
    int   gnt_a_run;
    @(negedge clk);

    // Reset with both requesting, then A wins first
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b1, 1'b1, 8'hAA, 8'hBB);
    expect_bit("reset_gnt_a", gnt_a, 1'b0);
    step("rel", 1'b0, 1'b1, 1'b1, 8'hA0, 8'hB0);
    expect_bit("first_is_a", gnt_a, 1'b1);
    step("rel_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Single A, four words
    for (int i = 0; i < 4; i++) step("single_a", 1'b0, 1'b1, 1'b0, 8'h11 + 8'(i), 8'h00);
    for (int i = 0; i < 3; i++) step("single_a_tail", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_bit("single_a_idle", gnt_a | gnt_b, 1'b0);

    // Contention from reset: A drops after 3 grants, B follows with no gap
    step("c_rst", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) step("contend", 1'b0, 1'b1, 1'b1, 8'h20 + 8'(i), 8'h30 + 8'(i));
    step("contend_drop", 1'b0, 1'b0, 1'b1, 8'h00, 8'h3F);
    expect_bit("contend_b_nogap", gnt_b, 1'b1);
    step("contend_b", 1'b0, 1'b0, 1'b1, 8'h00, 8'h40);
    step("contend_b", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Preemption: both held, grants alternate in tenures of MH
    step("p_rst", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3 * MH + 1; i++) step("preempt", 1'b0, 1'b1, 1'b1, 8'(i), 8'(8'h80 + i));
    step("p_end", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("p_end", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Renewal: A alone for 10 cycles keeps the grant continuously
    gnt_a_run = 0;
    for (int i = 0; i < 10; i++) begin
      step("renew", 1'b0, 1'b1, 1'b0, 8'h50 + 8'(i), 8'h00);
      if (gnt_a) gnt_a_run++;
    end
    total++;
    assert (gnt_a_run === 10) else begin
      bad++; $error("FAIL renew_run got=%0d exp=10", gnt_a_run);
    end
    step("renew_end", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Mid-tenure reset during GNT_B, then A first on release
    step("m_b", 1'b0, 1'b0, 1'b1, 8'h00, 8'hC1);
    step("m_b", 1'b0, 1'b0, 1'b1, 8'h00, 8'hC2);
    step("m_rst", 1'b1, 1'b1, 1'b1, 8'h00, 8'hC3);
    expect_bit("mrst_out_valid", out_valid, 1'b0);
    step("m_rel", 1'b0, 1'b1, 1'b1, 8'hD0, 8'hE0);
    expect_bit("mrst_a_first", gnt_a, 1'b1);

    // Randomized traffic with sticky request levels and rare resets
    a = 1'b0; b = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) a = ~a;
      if ($urandom_range(3) == 0) b = ~b;
      step("rand", ($urandom_range(63) == 0), a, b, 8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
